// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader that writes a checksummed program image into instruction memory
module imem_uart_loader #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int ADDR_W      = 8,
    parameter int MAX_WORDS   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_resetn,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);
    localparam int CPB   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_SYNC, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK, S_DONE, S_ERROR} ld_state_t;

    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t        r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_rx_shift;
    logic             w_tick_half, w_tick_full, w_byte_valid, w_frame_err;

    ld_state_t        r_state, w_next;
    logic [15:0]      r_cnt, r_idx, w_idx_inc, w_n;
    logic [7:0]       r_chk;
    logic [1:0]       r_bsel;
    logic [31:0]      r_asm, r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic             r_we, w_sync, w_word_end, w_busy;

    assign w_tick_half  = r_clk_cnt == HALF_M1;
    assign w_tick_full  = r_clk_cnt == FULL_M1;
    assign w_byte_valid = r_rx_state == RX_STOP && w_tick_full && r_rx_sync;
    assign w_frame_err  = r_rx_state == RX_STOP && w_tick_full && !r_rx_sync;

    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) {r_rx_prev, r_rx_sync, r_rx_meta} <= 3'b111;
        else       {r_rx_prev, r_rx_sync, r_rx_meta} <= {r_rx_sync, r_rx_meta, uart_rx};
    end

    // receiver state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    // receiver sequencing: start edge, mid-start glitch check, 8 data bits, stop bit
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  w_rx_next = (r_rx_prev && !r_rx_sync) ? RX_START : RX_IDLE;
            RX_START: if (w_tick_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick_full && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
            default:  if (w_tick_full) w_rx_next = RX_IDLE;
        endcase
    end

    // bit timer and LSB-first shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_shift <= '0;
        end else begin
            r_clk_cnt <= (r_rx_state == RX_IDLE || w_rx_next != r_rx_state ||
                          (r_rx_state == RX_DATA && w_tick_full)) ? '0 : r_clk_cnt + 1'b1;
            if (r_rx_state == RX_DATA && w_tick_full) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_bit_idx  <= r_bit_idx + 3'd1;
            end
        end
    end

    assign w_sync     = w_byte_valid && r_rx_shift == 8'hA5;
    assign w_n        = {r_rx_shift, r_cnt[7:0]};
    assign w_word_end = r_bsel == 2'd3;
    assign w_idx_inc  = r_idx + 16'd1;
    assign w_busy     = r_state inside {S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK};

    // loader state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_SYNC;
        else       r_state <= w_next;
    end

    // frame parser; a framing error while a load is in progress is fatal to that load
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SYNC, S_DONE, S_ERROR: w_next = w_sync ? S_CNT_LO : r_state;
            S_CNT_LO: w_next = w_byte_valid ? S_CNT_HI : S_CNT_LO;
            S_CNT_HI: if (w_byte_valid) w_next = (w_n > 16'(MAX_WORDS)) ? S_ERROR :
                                                 (w_n == 16'd0) ? S_CHECK : S_DATA;
            S_DATA:   if (w_byte_valid && w_word_end && w_idx_inc == r_cnt) w_next = S_CHECK;
            S_CHECK:  if (w_byte_valid) w_next = (r_rx_shift == r_chk) ? S_DONE : S_ERROR;
            default:  w_next = S_SYNC;
        endcase
        if (w_frame_err && w_busy) w_next = S_ERROR;
    end

    // count, checksum and word assembly; the write strobe fires the cycle after the 4th byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_chk   <= '0;
            r_bsel  <= '0;
            r_asm   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_byte_valid) begin
                if (w_sync && !w_busy) begin
                    r_chk  <= '0;
                    r_idx  <= '0;
                    r_bsel <= '0;
                end
                if (r_state == S_CNT_LO) r_cnt[7:0] <= r_rx_shift;
                if (r_state == S_CNT_HI) r_cnt[15:8] <= r_rx_shift;
                if (r_state inside {S_CNT_LO, S_CNT_HI, S_DATA}) r_chk <= r_chk ^ r_rx_shift;
                if (r_state == S_DATA) begin
                    r_asm  <= {r_rx_shift, r_asm[31:8]};
                    r_bsel <= r_bsel + 2'd1;
                    if (w_word_end) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_idx[ADDR_W-1:0];
                        r_wdata <= {r_rx_shift, r_asm[31:8]};
                        r_idx   <= w_idx_inc;
                    end
                end
            end
        end
    end

    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign core_resetn = r_state == S_DONE;
    assign busy        = w_busy;
    assign load_done   = r_state == S_DONE;
    assign load_error  = r_state == S_ERROR;
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: randomized frame-level checking of the UART boot loader against a parsing model
module tb_imem_uart_loader;
    logic        clk = 1'b0;
    logic        reset, uart_rx;
    logic        imem_we, core_resetn, busy, load_done, load_error;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    int          total = 0, bad = 0;
    logic [39:0] exp_wr[$];
    logic        exp_done = 1'b0, exp_err = 1'b0;
    logic [7:0]  q_byte[$];
    bit          q_ok[$];
    bit          run_chk = 1'b0;

    always #5 clk = ~clk;

    imem_uart_loader #(
        .CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .ADDR_W(8), .MAX_WORDS(256)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_resetn(core_resetn), .busy(busy),
        .load_done(load_done), .load_error(load_error)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk && !reset) begin
            if (imem_we) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", imem_addr, imem_wdata);
                end else check("write", {imem_addr, imem_wdata}, exp_wr.pop_front());
            end
            check("flag_consistency", {38'd0, core_resetn ^ load_done, load_done & load_error}, 40'd0);
            if (busy) check("busy_excl", {38'd0, load_done, load_error}, 40'd0);
        end
    end

    // frame-level reference: locate the sync byte, then interpret every later byte by its position
    task automatic model_frame();
        int i = 0;
        int n = 0;
        logic [7:0] chk = 8'd0;
        logic [31:0] w = 32'd0;
        while (i < q_byte.size() && !(q_ok[i] && q_byte[i] == 8'hA5)) i++;
        if (i == q_byte.size()) return;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int k = 1; i + k < q_byte.size(); k++) begin
            logic [7:0] b;
            b = q_byte[i + k];
            if (!q_ok[i + k]) begin exp_err = 1'b1; return; end
            if (k >= 3 && k == 3 + 4 * n) begin
                if (b == chk) exp_done = 1'b1; else exp_err = 1'b1;
                return;
            end
            chk ^= b;
            if (k == 1) n = b;
            else if (k == 2) begin
                n += b * 256;
                if (n > 256) begin exp_err = 1'b1; return; end
            end else begin
                w[8 * ((k - 3) % 4) +: 8] = b;
                if ((k - 3) % 4 == 3) exp_wr.push_back({8'((k - 3) / 4), w});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = ok;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (ok ? 2 : 16) @(negedge clk);
    endtask

    task automatic glitch();
        uart_rx = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        uart_rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_q(input bit glitches);
        for (int i = 0; i < q_byte.size(); i++) begin
            if (glitches && $urandom_range(0, 5) == 0) glitch();
            send_byte(q_byte[i], q_ok[i]);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit ok);
        q_byte.push_back(b);
        q_ok.push_back(ok);
    endtask

    task automatic end_checks(input string name);
        repeat (4) @(negedge clk);
        check({name, "_done"}, {39'd0, load_done}, {39'd0, exp_done});
        check({name, "_err"}, {39'd0, load_error}, {39'd0, exp_err});
        check({name, "_busy"}, {39'd0, busy}, 40'd0);
        check({name, "_coreresetn"}, {39'd0, core_resetn}, {39'd0, exp_done});
        check({name, "_pending"}, 40'(exp_wr.size()), 40'd0);
    endtask

    task automatic run_frame(input string name, input bit glitches);
        model_frame();
        send_q(glitches);
        end_checks(name);
        q_byte.delete();
        q_ok.delete();
    endtask

    task automatic good_frame2();
        push(8'hA5, 1); push(8'h02, 1); push(8'h00, 1);
        push(8'hDE, 1); push(8'hAD, 1); push(8'hBE, 1); push(8'hEF, 1);
        push(8'h01, 1); push(8'h02, 1); push(8'h03, 1); push(8'h04, 1);
        push(8'h02 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 1);
    endtask

    initial begin
        reset = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {imem_we, core_resetn, busy, load_done, load_error, imem_addr, imem_wdata[26:0]}, 40'd0);
        check("reset_wdata_hi", {35'd0, imem_wdata[31:27]}, 40'd0);
        reset = 1'b0;
        run_chk = 1'b1;
        repeat (4) @(negedge clk);

        push(8'hA5, 1); push(8'h01, 1); push(8'h00, 1); push(8'h13, 1);
        push(8'h05, 1); push(8'h50, 1); push(8'h00, 1); push(8'h47, 1);
        model_frame();
        check("t1_model_word", exp_wr[0], {8'h00, 32'h00500513});
        check("t1_model_done", {39'd0, exp_done}, 40'd1);
        send_byte(8'hA5, 1);
        check("t1_busy_after_sync", {38'd0, busy, core_resetn}, 40'd2);
        for (int i = 1; i < q_byte.size(); i++) send_byte(q_byte[i], q_ok[i]);
        end_checks("t1");
        q_byte.delete(); q_ok.delete();

        push(8'hA5, 1); push(8'h02, 1); push(8'h00, 1);
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11), 1);
        push(8'h8B, 1);
        model_frame();
        check("t2_model_w0", exp_wr[0], {8'h00, 32'h44332211});
        check("t2_model_w1", exp_wr[1], {8'h01, 32'h88776655});
        check("t2_model_err", {39'd0, exp_err}, 40'd1);
        send_q(0);
        end_checks("t2");
        q_byte.delete(); q_ok.delete();

        push(8'hA5, 1); push(8'h01, 1); push(8'h01, 1);
        run_frame("t3_oversize", 0);

        push(8'h3C, 1); push(8'h00, 1); push(8'hA5, 1); push(8'h00, 1); push(8'h00, 1); push(8'h00, 1);
        model_frame();
        check("t4_model_done", {39'd0, exp_done}, 40'd1);
        send_q(0);
        end_checks("t4_empty");
        q_byte.delete(); q_ok.delete();

        push(8'hA5, 1); push(8'h01, 1); push(8'h00, 1); push(8'h13, 1); push(8'h05, 0);
        run_frame("t5_framing", 0);
        good_frame2();
        run_frame("t5_recover", 0);

        for (int r = 0; r < 10; r++) begin
            int kind, n, sidx;
            logic [7:0] chk, b;
            logic [15:0] big;
            kind = $urandom_range(0, 5);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                b = 8'($urandom_range(0, 255));
                push(b == 8'hA5 ? 8'h5A : b, $urandom_range(0, 3) != 0);
            end
            sidx = q_byte.size();
            push(8'hA5, 1);
            if (kind == 0) begin
                big = 16'($urandom_range(257, 1200));
                push(big[7:0], 1); push(big[15:8], 1);
            end else begin
                n = $urandom_range(0, 3);
                chk = 8'(n);
                push(8'(n), 1); push(8'h00, 1);
                for (int j = 0; j < 4 * n; j++) begin
                    b = 8'($urandom_range(0, 255));
                    chk ^= b;
                    push(b, 1);
                end
                push(kind == 1 ? chk ^ 8'($urandom_range(1, 255)) : chk, 1);
                if (kind == 2) begin
                    int e;
                    e = sidx + $urandom_range(1, q_byte.size() - sidx - 1);
                    q_ok[e] = 1'b0;
                    while (q_byte.size() > e + 1) begin
                        void'(q_byte.pop_back());
                        void'(q_ok.pop_back());
                    end
                end
            end
            run_frame($sformatf("rand%0d", r), 1);
        end

        push(8'hA5, 1); push(8'h01, 1); push(8'h00, 1); push(8'h13, 1); push(8'h05, 1);
        model_frame();
        send_q(0);
        q_byte.delete(); q_ok.delete();
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t6_async_reset", {imem_we, core_resetn, busy, load_done, load_error, imem_addr, imem_wdata[26:0]}, 40'd0);
        check("t6_reset_wdata_hi", {35'd0, imem_wdata[31:27]}, 40'd0);
        exp_wr.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        good_frame2();
        run_frame("t6_reload", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
